// File: rtl/risc_pkg.sv
// Shared definitions for the IITB-RISC datapath blocks: default widths,
// the PC register index and the LM/SM sequencer state encoding.
package risc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // R7 doubles as the program counter
  localparam logic [2:0] REG_PC = 3'd7;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ACCESS = 2'd1,
    SEQ_DONE   = 2'd2
  } seq_state_e;

  // Drop one register from a pending transfer list
  function automatic logic [7:0] bit_clear8(input logic [7:0] mask,
                                            input logic [2:0] idx);
    bit_clear8 = mask & ~(8'b1 << idx);
  endfunction

endpackage

// File: rtl/lowest_set_bit8.sv
// Combinational priority encoder: index of the lowest set bit of an 8-bit
// mask. valid is low for an empty mask, in which case index reads 0.
module lowest_set_bit8 (
  input  logic [7:0] mask,
  output logic [2:0] index,
  output logic       valid
);

  // Scan from the top so the lowest set bit is the last one to win
  always_comb begin
    index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) index = 3'(i);
    end
  end

  assign valid = |mask;

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer. Walks the register list from
// R0 upward, one data-memory access per listed register, and holds the
// pipeline stalled (busy) until the list is exhausted.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   SEQ_IDLE   | waiting for start; all outputs quiet
//   SEQ_ACCESS | one access in flight for the lowest pending register
//   SEQ_DONE   | one-cycle completion pulse, then back to SEQ_IDLE
module lm_sm_sequencer
  import risc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [7:0]        reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        rf_read_addr,
  output logic              rf_write_en,
  output logic [2:0]        rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data
);

  seq_state_e        state, state_nxt;
  logic              load_q, load_nxt;
  logic [7:0]        pend_q, pend_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;

  logic [2:0]        cur_idx;
  logic              cur_valid;

  lowest_set_bit8 u_lsb (
    .mask  (pend_q),
    .index (cur_idx),
    .valid (cur_valid)
  );

  // State and operand registers; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SEQ_IDLE;
      load_q <= 1'b0;
      pend_q <= 8'd0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      load_q <= load_nxt;
      pend_q <= pend_nxt;
      addr_q <= addr_nxt;
    end
  end

  // Next-state and all outputs; outputs are forced quiet while reset is
  // high so a mid-access reset cannot leak a register write
  always_comb begin
    state_nxt     = state;
    load_nxt      = load_q;
    pend_nxt      = pend_q;
    addr_nxt      = addr_q;
    busy          = 1'b0;
    done          = 1'b0;
    mem_addr      = '0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_wdata     = '0;
    rf_read_addr  = 3'd0;
    rf_write_en   = 1'b0;
    rf_write_addr = 3'd0;
    rf_write_data = '0;

    if (!reset) begin
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            load_nxt  = is_load;
            pend_nxt  = reg_mask;
            addr_nxt  = base_addr;
            state_nxt = (reg_mask != 8'd0) ? SEQ_ACCESS : SEQ_DONE;
          end
        end

        SEQ_ACCESS: begin
          busy     = 1'b1;
          mem_addr = addr_q;
          if (load_q) begin
            mem_read_en = 1'b1;
            // A load into the PC still consumes its memory word but is
            // never written back; PC updates belong to the fetch logic
            if (mem_ready && (cur_idx != REG_PC)) begin
              rf_write_en   = 1'b1;
              rf_write_addr = cur_idx;
              rf_write_data = mem_rdata;
            end
          end else begin
            mem_write_en = 1'b1;
            rf_read_addr = cur_idx;
            mem_wdata    = rf_read_data;
          end

          if (mem_ready) begin
            pend_nxt = bit_clear8(pend_q, cur_idx);
            addr_nxt = addr_q + ADDR_W'(1);
            if (pend_nxt == 8'd0) state_nxt = SEQ_DONE;
          end
          // Defensive: an empty list here can only come from a corrupted
          // register, so finish rather than spin
          if (!cur_valid) state_nxt = SEQ_DONE;
        end

        SEQ_DONE: begin
          busy      = 1'b1;
          done      = 1'b1;
          state_nxt = SEQ_IDLE;
        end

        default: state_nxt = SEQ_IDLE;
      endcase
    end
  end

endmodule
